ddr3_tile_wr_sched: RTL and testbench

DDR3_TILE_WR_SCHED -- requirements
Module: ddr3_tile_wr_sched

---
 rtl/ddr3_tile_pkg.sv | 25 ++
 rtl/ddr3_tile_wr_sched_rr_arbiter.sv | 43 ++++
 rtl/ddr3_tile_wr_sched.sv | 214 +++++++++++++++++++++
 tb/tb_ddr3_tile_wr_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_tile_pkg.sv
// Shared definitions for the DDR3 tile write scheduler: FSM encodings,
// tiling mode encoding and channel-count helpers.
package ddr3_tile_pkg;

    localparam int MAX_CH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef enum logic {
        MODE_SBS  = 1'b0,
        MODE_QUAD = 1'b1
    } tile_mode_e;

    // Side-by-side tile width shift: log2 of the channel count.
    function automatic int ch_shift(input int n);
        return (n >= 4) ? 2 : ((n >= 2) ? 1 : 0);
    endfunction

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr3_tile_wr_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the channel after the
// last committed grant; the pointer only moves when a burst commits.
module rr_arbiter
    import ddr3_tile_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int CH_W = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              commit,
    input  logic [CH_W-1:0]   commit_ch,
    output logic [NUM_CH-1:0] grant
);

    logic [CH_W-1:0] ptr_reg;
    logic [CH_W-1:0] idx;
    logic            found;

    // Channel counts are powers of two, so the index wraps naturally.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr_reg + CH_W'(i);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (commit) begin
            ptr_reg <= (NUM_CH == 1) ? '0 : commit_ch + CH_W'(1);
        end
    end

endmodule

// File: rtl/ddr3_tile_wr_sched.sv
// Schedules per-line write bursts from NUM_CH camera FIFOs into tiles of a
// shared DDR3 frame buffer (side-by-side or 2x2 layout).
module ddr3_tile_wr_sched
    import ddr3_tile_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 28,
    parameter int LEN_W  = 10,
    parameter int LINE_W = 12,
    localparam int CH_W  = ch_idx_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_load,
    input  logic                    cfg_mode,
    input  logic [LINE_W-1:0]       cfg_frame_w,
    input  logic [LINE_W-1:0]       cfg_frame_h,
    input  logic [ADDR_W-1:0]       cfg_base,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_vsync,
    input  logic [NUM_CH*LEN_W-1:0] ch_fifo_cnt,
    output logic                    wr_req,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [LEN_W-1:0]        wr_len,
    output logic [CH_W-1:0]         wr_ch,
    input  logic                    wr_ack,
    input  logic                    wr_done,
    output logic [NUM_CH-1:0]       frame_done,
    output logic [NUM_CH-1:0]       short_frame
);

    localparam int SH    = ch_shift(NUM_CH);
    localparam int CMP_W = (LEN_W > LINE_W) ? LEN_W : LINE_W;

    logic [1:0]        state_reg;
    logic [CH_W-1:0]   grant_ch_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [LEN_W-1:0]  wr_len_reg;

    tile_mode_e        mode_reg;
    logic [LINE_W-1:0] frame_w_reg;
    logic [LINE_W-1:0] frame_h_reg;
    logic [ADDR_W-1:0] base_reg;

    logic [NUM_CH-1:0] armed_reg, armed_next;
    logic [NUM_CH-1:0] pend_reg, pend_next;
    logic [NUM_CH-1:0] vsync_d_reg;
    logic [NUM_CH-1:0] frame_done_reg, frame_done_next;
    logic [NUM_CH-1:0] short_frame_reg, short_frame_next;
    logic [LINE_W-1:0] line_reg  [NUM_CH];
    logic [LINE_W-1:0] line_next [NUM_CH];

    logic [LEN_W-1:0]  fifo_cnt [NUM_CH];
    logic [NUM_CH-1:0] vs_ev;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_any;
    logic              commit;

    logic [LINE_W-1:0] tw, th;
    logic              tw_nz;
    logic [1:0]        gsel;
    logic [ADDR_W-1:0] row_off, col_off, addr_calc;

    assign tw    = (mode_reg == MODE_QUAD) ? (frame_w_reg >> 1) : (frame_w_reg >> SH);
    assign th    = (mode_reg == MODE_QUAD) ? (frame_h_reg >> 1) : frame_h_reg;
    assign tw_nz = (tw != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign fifo_cnt[gi] = ch_fifo_cnt[gi*LEN_W +: LEN_W];
            assign vs_ev[gi]    = ch_vsync[gi] & ~vsync_d_reg[gi] & ch_en[gi];
            assign elig[gi]     = armed_reg[gi] & ch_en[gi] & (line_reg[gi] < th) & tw_nz
                                  & (CMP_W'(fifo_cnt[gi]) >= CMP_W'(tw));
        end
    endgenerate

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (elig),
        .commit    (commit),
        .commit_ch (grant_ch_reg),
        .grant     (grant)
    );

    assign grant_any = |grant;

    always_comb begin
        grant_idx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) grant_idx = CH_W'(c);
        end
    end

    assign commit = ((state_reg == ST_REQ) && wr_ack && wr_done) ||
                    ((state_reg == ST_WAIT) && wr_done);

    // Tile origin of the winning channel; products wrap at ADDR_W bits.
    assign gsel = 2'(grant_idx);

    always_comb begin
        row_off = '0;
        col_off = '0;
        if (mode_reg == MODE_QUAD) begin
            if (gsel[0]) col_off = ADDR_W'(tw);
            if (gsel[1]) row_off = ADDR_W'(th);
        end else begin
            col_off = ADDR_W'(grant_idx) * ADDR_W'(tw);
        end
        addr_calc = base_reg
                  + (row_off + ADDR_W'(line_reg[grant_idx])) * ADDR_W'(frame_w_reg)
                  + col_off;
    end

    // Per-channel arm/line bookkeeping. A vsync edge on the channel owning
    // the in-flight burst is parked in pend_reg and applied at its commit.
    always_comb begin
        armed_next       = armed_reg;
        pend_next        = pend_reg;
        frame_done_next  = '0;
        short_frame_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            line_next[c] = line_reg[c];
            if (vs_ev[c]) begin
                short_frame_next[c] = armed_reg[c] && (line_reg[c] < th) && (line_reg[c] != '0);
            end
            if (commit && (int'(grant_ch_reg) == c)) begin
                if (pend_reg[c] || vs_ev[c]) begin
                    armed_next[c] = 1'b1;
                    line_next[c]  = '0;
                    pend_next[c]  = 1'b0;
                end else begin
                    line_next[c] = line_reg[c] + LINE_W'(1);
                    if ((line_reg[c] + LINE_W'(1)) == th) begin
                        frame_done_next[c] = 1'b1;
                        armed_next[c]      = 1'b0;
                    end
                end
            end else if (vs_ev[c]) begin
                if ((state_reg != ST_IDLE) && (int'(grant_ch_reg) == c)) begin
                    pend_next[c] = 1'b1;
                end else begin
                    armed_next[c] = 1'b1;
                    line_next[c]  = '0;
                end
            end
            if (!ch_en[c]) begin
                armed_next[c] = 1'b0;
                pend_next[c]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            grant_ch_reg    <= '0;
            wr_addr_reg     <= '0;
            wr_len_reg      <= '0;
            mode_reg        <= MODE_SBS;
            frame_w_reg     <= '0;
            frame_h_reg     <= '0;
            base_reg        <= '0;
            armed_reg       <= '0;
            pend_reg        <= '0;
            vsync_d_reg     <= '0;
            frame_done_reg  <= '0;
            short_frame_reg <= '0;
            for (int c = 0; c < NUM_CH; c++) line_reg[c] <= '0;
        end else begin
            armed_reg       <= armed_next;
            pend_reg        <= pend_next;
            vsync_d_reg     <= ch_vsync;
            frame_done_reg  <= frame_done_next;
            short_frame_reg <= short_frame_next;
            for (int c = 0; c < NUM_CH; c++) line_reg[c] <= line_next[c];

            case (state_reg)
                ST_IDLE: begin
                    if (cfg_load) begin
                        mode_reg    <= tile_mode_e'(cfg_mode);
                        frame_w_reg <= cfg_frame_w;
                        frame_h_reg <= cfg_frame_h;
                        base_reg    <= cfg_base;
                    end
                    if (grant_any) begin
                        state_reg    <= ST_REQ;
                        grant_ch_reg <= grant_idx;
                        wr_addr_reg  <= addr_calc;
                        wr_len_reg   <= LEN_W'(tw);
                    end
                end
                ST_REQ: begin
                    if (wr_ack) state_reg <= wr_done ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wr_done) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign wr_req      = (state_reg == ST_REQ);
    assign wr_addr     = wr_addr_reg;
    assign wr_len      = wr_len_reg;
    assign wr_ch       = grant_ch_reg;
    assign frame_done  = frame_done_reg;
    assign short_frame = short_frame_reg;

endmodule

// File: tb/tb_ddr3_tile_wr_sched.sv
// Directed bench for the tile write scheduler: a 2-channel instance carries
// most scenarios, a 4-channel instance covers the 2x2 quad layout.
module tb_ddr3_tile_wr_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 2-channel instance
    logic        a_cfg_load, a_cfg_mode;
    logic [11:0] a_cfg_w, a_cfg_h;
    logic [27:0] a_cfg_base;
    logic [1:0]  a_en, a_vs;
    logic [19:0] a_fifo;
    logic        a_req, a_ack, a_done;
    logic [27:0] a_addr;
    logic [9:0]  a_len;
    logic [0:0]  a_ch;
    logic [1:0]  a_fd, a_sf;

    // 4-channel instance
    logic        b_cfg_load, b_cfg_mode;
    logic [11:0] b_cfg_w, b_cfg_h;
    logic [27:0] b_cfg_base;
    logic [3:0]  b_en, b_vs;
    logic [39:0] b_fifo;
    logic        b_req, b_ack, b_done;
    logic [27:0] b_addr;
    logic [9:0]  b_len;
    logic [1:0]  b_ch;
    logic [3:0]  b_fd, b_sf;

    ddr3_tile_wr_sched #(.NUM_CH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cfg_load(a_cfg_load), .cfg_mode(a_cfg_mode), .cfg_frame_w(a_cfg_w),
        .cfg_frame_h(a_cfg_h), .cfg_base(a_cfg_base),
        .ch_en(a_en), .ch_vsync(a_vs), .ch_fifo_cnt(a_fifo),
        .wr_req(a_req), .wr_addr(a_addr), .wr_len(a_len), .wr_ch(a_ch),
        .wr_ack(a_ack), .wr_done(a_done),
        .frame_done(a_fd), .short_frame(a_sf)
    );

    ddr3_tile_wr_sched #(.NUM_CH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cfg_load(b_cfg_load), .cfg_mode(b_cfg_mode), .cfg_frame_w(b_cfg_w),
        .cfg_frame_h(b_cfg_h), .cfg_base(b_cfg_base),
        .ch_en(b_en), .ch_vsync(b_vs), .ch_fifo_cnt(b_fifo),
        .wr_req(b_req), .wr_addr(b_addr), .wr_len(b_len), .wr_ch(b_ch),
        .wr_ack(b_ack), .wr_done(b_done),
        .frame_done(b_fd), .short_frame(b_sf)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wait_req(input string tag);
        int i;
        i = 0;
        while (!a_req && i < 40) begin
            tick();
            i++;
        end
        chk({tag, " req"}, 32'(a_req), 32'd1);
    endtask

    task automatic b_wait_req(input string tag);
        int i;
        i = 0;
        while (!b_req && i < 40) begin
            tick();
            i++;
        end
        chk({tag, " req"}, 32'(b_req), 32'd1);
    endtask

    // Accept the pending request; same=1 acks and completes in one cycle.
    task automatic a_serve(input bit same, output logic [1:0] fd);
        a_ack  = 1'b1;
        a_done = same;
        tick();
        a_ack  = 1'b0;
        a_done = 1'b0;
        if (!same) begin
            tick();
            a_done = 1'b1;
            tick();
            a_done = 1'b0;
        end
        fd = a_fd;
    endtask

    task automatic a_load(input logic mode, input logic [11:0] w, input logic [11:0] h,
                          input logic [27:0] base);
        a_cfg_mode = mode; a_cfg_w = w; a_cfg_h = h; a_cfg_base = base;
        a_cfg_load = 1'b1;
        tick();
        a_cfg_load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] fd;
        logic [1:0] last_fd;
        int         fd_cnt;
        bit         seen;

        a_cfg_load = 0; a_cfg_mode = 0; a_cfg_w = 0; a_cfg_h = 0; a_cfg_base = 0;
        a_en = 0; a_vs = 0; a_fifo = 0; a_ack = 0; a_done = 0;
        b_cfg_load = 0; b_cfg_mode = 0; b_cfg_w = 0; b_cfg_h = 0; b_cfg_base = 0;
        b_en = 0; b_vs = 0; b_fifo = 0; b_ack = 0; b_done = 0;
        last_fd = 0; fd_cnt = 0;

        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset wr_req", 32'(a_req), 32'd0);
        chk("reset wr_addr", 32'(a_addr), 32'd0);
        chk("reset wr_len", 32'(a_len), 32'd0);
        chk("reset wr_ch", 32'(a_ch), 32'd0);
        chk("reset frame_done", 32'(a_fd), 32'd0);
        chk("reset short_frame", 32'(a_sf), 32'd0);
        chk("reset quad wr_req", 32'(b_req), 32'd0);
        rst_n = 1'b1;
        tick();

        // Quad layout, 4 channels, 1024x768: tiles 512x384.
        b_cfg_mode = 1'b1; b_cfg_w = 12'd1024; b_cfg_h = 12'd768; b_cfg_base = 0;
        b_cfg_load = 1'b1;
        tick();
        b_cfg_load = 1'b0;
        b_en = 4'b1100;
        b_fifo = {4{10'd512}};
        b_vs = 4'b1100;
        tick();
        b_vs = 4'b0000;
        b_wait_req("quad first");
        chk("quad first ch", 32'(b_ch), 32'd2);
        chk("quad ch2 addr", 32'(b_addr), 32'd393216);
        chk("quad ch2 len", 32'(b_len), 32'd512);
        b_ack = 1'b1; b_done = 1'b1;
        tick();
        b_ack = 1'b0; b_done = 1'b0;
        b_wait_req("quad second");
        chk("quad second ch", 32'(b_ch), 32'd3);
        chk("quad ch3 addr", 32'(b_addr), 32'd393728);
        chk("quad ch3 len", 32'(b_len), 32'd512);
        b_ack = 1'b1; b_done = 1'b1;
        tick();
        b_ack = 1'b0; b_done = 1'b0;
        b_en = 4'b0000;

        // Side-by-side, channel 0 alone: 512-word lines at stride 1024.
        a_load(1'b0, 12'd1024, 12'd768, 28'd0);
        a_en = 2'b01;
        a_fifo = {10'd0, 10'd512};
        a_vs = 2'b01;
        tick();
        a_vs = 2'b00;
        a_wait_req("sbs line0");
        chk("sbs line0 addr", 32'(a_addr), 32'd0);
        chk("sbs line0 len", 32'(a_len), 32'd512);
        chk("sbs line0 ch", 32'(a_ch), 32'd0);
        repeat (3) tick();
        chk("req held without ack", 32'(a_req), 32'd1);
        chk("addr stable without ack", 32'(a_addr), 32'd0);
        a_serve(1'b0, fd);
        a_wait_req("sbs line1");
        chk("sbs line1 addr", 32'(a_addr), 32'd1024);
        a_serve(1'b1, fd);
        a_wait_req("sbs line2");
        chk("sbs line2 addr", 32'(a_addr), 32'd2048);
        a_serve(1'b1, fd);

        for (int l = 3; l < 768; l++) begin
            a_wait_req("frame loop");
            if (l == 767) chk("last line addr", 32'(a_addr), 32'd785408);
            a_serve(1'b1, fd);
            if (fd[0]) fd_cnt++;
            if (l == 767) last_fd = fd;
        end
        chk("frame_done on last commit", 32'(last_fd), 32'd1);
        chk("frame_done count", 32'(fd_cnt), 32'd1);
        tick();
        chk("frame_done one cycle", 32'(a_fd), 32'd0);
        seen = 0;
        repeat (20) begin
            tick();
            if (a_req) seen = 1;
        end
        chk("no req after frame end", 32'(seen), 32'd0);

        // Fresh start: both channels eligible alternate grants.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        a_load(1'b0, 12'd1024, 12'd768, 28'd0);
        a_en = 2'b11;
        a_fifo = {10'd512, 10'd512};
        a_vs = 2'b11;
        tick();
        a_vs = 2'b00;
        a_wait_req("rr 1");
        chk("rr 1 ch", 32'(a_ch), 32'd0);
        chk("rr 1 addr", 32'(a_addr), 32'd0);
        a_serve(1'b1, fd);
        a_wait_req("rr 2");
        chk("rr 2 ch", 32'(a_ch), 32'd1);
        chk("rr 2 addr", 32'(a_addr), 32'd512);
        a_serve(1'b1, fd);
        a_wait_req("rr 3");
        chk("rr 3 ch", 32'(a_ch), 32'd0);
        chk("rr 3 addr", 32'(a_addr), 32'd1024);
        a_serve(1'b1, fd);
        a_wait_req("rr 4");
        chk("rr 4 ch", 32'(a_ch), 32'd1);
        chk("rr 4 addr", 32'(a_addr), 32'd1536);
        a_serve(1'b1, fd);

        // Drop ch1, run ch0 to line 100, then restart its frame mid-burst.
        a_en = 2'b01;
        for (int l = 2; l < 100; l++) begin
            a_wait_req("to line 100");
            chk("to line 100 ch", 32'(a_ch), 32'd0);
            a_serve(1'b1, fd);
        end
        a_wait_req("line 100");
        chk("line 100 addr", 32'(a_addr), 32'd102400);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        a_cfg_w = 12'd512;
        a_cfg_load = 1'b1;
        a_vs = 2'b01;
        tick();
        a_cfg_load = 1'b0;
        a_vs = 2'b00;
        a_cfg_w = 12'd1024;
        chk("short_frame pulse", 32'(a_sf), 32'd1);
        chk("no req while waiting", 32'(a_req), 32'd0);
        tick();
        chk("short_frame one cycle", 32'(a_sf), 32'd0);
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        chk("no frame_done on restart", 32'(a_fd), 32'd0);
        a_wait_req("restart line0");
        chk("restart line0 addr", 32'(a_addr), 32'd0);
        a_serve(1'b1, fd);
        a_wait_req("restart line1");
        chk("cfg ignored when busy", 32'(a_addr), 32'd1024);
        a_serve(1'b1, fd);

        // Reset while a request is pending.
        a_wait_req("pre reset");
        rst_n = 1'b0;
        #1;
        chk("reset drops wr_req", 32'(a_req), 32'd0);
        chk("reset clears wr_addr", 32'(a_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (a_req) seen = 1;
        end
        chk("no req after reset", 32'(seen), 32'd0);
        a_load(1'b0, 12'd1024, 12'd768, 28'd100);
        seen = 0;
        repeat (20) begin
            tick();
            if (a_req) seen = 1;
        end
        chk("no req before vsync", 32'(seen), 32'd0);
        a_vs = 2'b01;
        tick();
        a_vs = 2'b00;
        a_wait_req("post reset");
        chk("post reset addr", 32'(a_addr), 32'd100);
        chk("post reset len", 32'(a_len), 32'd512);
        a_serve(1'b1, fd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
